// File: rtl/seat_allocator.sv
// Round-robin seat allocator in front of the seat-table RAM: claims one free seat per
// request, issues a single registered write to the table and services seat releases.
module seat_allocator #(
    parameter int NUM_SEATS = 32,
    parameter int SNO_W     = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SNO_W-1:0] req_student_no,
    input  logic             rel_valid,
    input  logic [4:0]       rel_seat_no,
    output logic             rel_err,
    output logic             write_mem1,
    output logic [SNO_W-1:0] Student_No_mem1,
    output logic [4:0]       Seat_No_mem1,
    output logic             assign_valid,
    output logic [4:0]       assign_seat_no,
    output logic             assign_full,
    output logic [5:0]       free_count
);

    localparam logic [5:0] LP_NUM_SEATS = 6'(NUM_SEATS);
    localparam logic [4:0] LP_LAST_SEAT = 5'(NUM_SEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    // Full 32-bit bitmap; bits at or above NUM_SEATS are never set.
    logic [31:0]        r_occ;
    logic [31:0]        w_occ_nxt;
    logic [4:0]         r_ptr;
    logic [4:0]         w_ptr_nxt;
    logic [5:0]         r_free_count;
    logic [5:0]         w_free_nxt;

    logic               r_req_ready;
    logic               r_write_mem1;
    logic [SNO_W-1:0]   r_student_no;
    logic [4:0]         r_seat_no;
    logic               r_assign_valid;
    logic [4:0]         r_assign_seat;
    logic               r_assign_full;
    logic               r_rel_err;

    logic               w_accept;
    logic               w_probe_free;
    logic               w_claim;
    logic               w_rel_in_range;
    logic               w_rel_ok;
    logic [4:0]         w_ptr_inc;
    logic [4:0]         w_seat_inc;

    assign w_accept     = (r_state == ST_IDLE) && r_req_ready && req_valid;
    assign w_probe_free = !r_occ[r_ptr];
    assign w_ptr_inc    = (r_ptr == LP_LAST_SEAT) ? 5'd0 : r_ptr + 5'd1;
    assign w_seat_inc   = (r_seat_no == LP_LAST_SEAT) ? 5'd0 : r_seat_no + 5'd1;

    // NOTE: every signal driven here gets a default first, so no path leaves a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_claim     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (r_free_count == 6'd0) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_SEARCH;
                    end
                end
            end
            ST_SEARCH: begin
                if (w_probe_free) begin
                    w_state_nxt = ST_WRITE;
                end else begin
                    w_ptr_nxt = w_ptr_inc;
                end
            end
            ST_WRITE: begin
                w_claim     = 1'b1;
                w_ptr_nxt   = w_seat_inc;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // A release may not free the seat that is being claimed in this very cycle.
    always_comb begin
        w_rel_in_range = ({1'b0, rel_seat_no} < LP_NUM_SEATS);
        w_rel_ok       = rel_valid && w_rel_in_range && r_occ[rel_seat_no]
                         && !((r_state == ST_WRITE) && (rel_seat_no == r_seat_no));
        w_occ_nxt      = r_occ;
        if (w_claim) begin
            w_occ_nxt[r_seat_no] = 1'b1;
        end
        if (w_rel_ok) begin
            w_occ_nxt[rel_seat_no] = 1'b0;
        end
        w_free_nxt = r_free_count - {5'd0, w_claim} + {5'd0, w_rel_ok};
    end

    // NOTE: the occupancy bitmap is plain flops rather than a RAM, so it is reset
    // together with the rest of the state; sequential state uses non-blocking only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_occ          <= '0;
            r_ptr          <= '0;
            r_free_count   <= LP_NUM_SEATS;
            r_req_ready    <= 1'b0;
            r_write_mem1   <= 1'b0;
            r_student_no   <= '0;
            r_seat_no      <= '0;
            r_assign_valid <= 1'b0;
            r_assign_seat  <= '0;
            r_assign_full  <= 1'b0;
            r_rel_err      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_occ          <= w_occ_nxt;
            r_ptr          <= w_ptr_nxt;
            r_free_count   <= w_free_nxt;
            r_req_ready    <= (w_state_nxt == ST_IDLE);
            r_write_mem1   <= (w_state_nxt == ST_WRITE);
            r_assign_valid <= (w_state_nxt == ST_DONE);
            r_assign_full  <= (w_state_nxt == ST_DONE) && (r_state == ST_IDLE);
            r_rel_err      <= rel_valid && !w_rel_ok;
            if (w_accept) begin
                r_student_no <= req_student_no;
            end
            // Seat address tracks the probe pointer, so it is stable a cycle before the strobe.
            if (w_state_nxt == ST_SEARCH) begin
                r_seat_no <= w_ptr_nxt;
            end
            if (w_state_nxt == ST_DONE) begin
                r_assign_seat <= (r_state == ST_IDLE) ? 5'd0 : r_seat_no;
            end
        end
    end

    assign req_ready       = r_req_ready;
    assign write_mem1      = r_write_mem1;
    assign Student_No_mem1 = r_student_no;
    assign Seat_No_mem1    = r_seat_no;
    assign assign_valid    = r_assign_valid;
    assign assign_seat_no  = r_assign_seat;
    assign assign_full     = r_assign_full;
    assign rel_err         = r_rel_err;
    assign free_count      = r_free_count;

endmodule

// File: tb/tb_seat_allocator.sv
// Self-checking bench for seat_allocator: directed scenarios plus randomized
// request/release traffic against a seat-list reference model.
module tb_seat_allocator;

    localparam int N = 32;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_student_no = '0;
    logic        rel_valid = 1'b0;
    logic [4:0]  rel_seat_no = '0;
    logic        rel_err;
    logic        write_mem1;
    logic [31:0] Student_No_mem1;
    logic [4:0]  Seat_No_mem1;
    logic        assign_valid;
    logic [4:0]  assign_seat_no;
    logic        assign_full;
    logic [5:0]  free_count;

    logic        t20_req_valid = 1'b0;
    logic        t20_req_ready;
    logic [31:0] t20_req_student_no = '0;
    logic        t20_rel_valid = 1'b0;
    logic [4:0]  t20_rel_seat_no = '0;
    logic        t20_rel_err;
    logic        t20_write_mem1;
    logic [31:0] t20_student_no_mem1;
    logic [4:0]  t20_seat_no_mem1;
    logic        t20_assign_valid;
    logic [4:0]  t20_assign_seat_no;
    logic        t20_assign_full;
    logic [5:0]  t20_free_count;

    seat_allocator #(.NUM_SEATS(N), .SNO_W(32)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_student_no(req_student_no),
        .rel_valid(rel_valid), .rel_seat_no(rel_seat_no), .rel_err(rel_err),
        .write_mem1(write_mem1), .Student_No_mem1(Student_No_mem1), .Seat_No_mem1(Seat_No_mem1),
        .assign_valid(assign_valid), .assign_seat_no(assign_seat_no),
        .assign_full(assign_full), .free_count(free_count)
    );

    seat_allocator #(.NUM_SEATS(20), .SNO_W(32)) u_dut20 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(t20_req_valid), .req_ready(t20_req_ready), .req_student_no(t20_req_student_no),
        .rel_valid(t20_rel_valid), .rel_seat_no(t20_rel_seat_no), .rel_err(t20_rel_err),
        .write_mem1(t20_write_mem1), .Student_No_mem1(t20_student_no_mem1),
        .Seat_No_mem1(t20_seat_no_mem1), .assign_valid(t20_assign_valid),
        .assign_seat_no(t20_assign_seat_no), .assign_full(t20_assign_full),
        .free_count(t20_free_count)
    );

    int n_vec = 0;
    int n_err = 0;

    bit model_occ[N];
    int model_ptr = 0;
    int g_av_seat = 0;
    int g_wr_cycle = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_free();
        int f = 0;
        for (int i = 0; i < N; i++) if (!model_occ[i]) f++;
        return f;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) model_occ[i] = 1'b0;
        model_ptr = 0;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},    64'(req_ready),       64'(0));
        check({tag, "_write_mem1"},   64'(write_mem1),      64'(0));
        check({tag, "_student_mem1"}, 64'(Student_No_mem1), 64'(0));
        check({tag, "_seat_mem1"},    64'(Seat_No_mem1),    64'(0));
        check({tag, "_assign_valid"}, 64'(assign_valid),    64'(0));
        check({tag, "_assign_seat"},  64'(assign_seat_no),  64'(0));
        check({tag, "_assign_full"},  64'(assign_full),     64'(0));
        check({tag, "_rel_err"},      64'(rel_err),         64'(0));
        check({tag, "_free_count"},   64'(free_count),      64'(N));
    endtask

    task automatic do_release(input logic [4:0] seat);
        bit ok;
        ok = (int'(seat) < N) && model_occ[seat];
        rel_valid   = 1'b1;
        rel_seat_no = seat;
        tick();
        rel_valid = 1'b0;
        check("rel_err", 64'(rel_err), 64'(!ok));
        if (ok) model_occ[seat] = 1'b0;
        check("rel_free_count", 64'(free_count), 64'(model_free()));
        tick();
        check("rel_err_pulse", 64'(rel_err), 64'(0));
    endtask

    // Issues one request; optionally strobes a release during the write cycle.
    task automatic do_request(input logic [31:0] sno, input bit rel_en, input logic [4:0] rel_seat);
        bit          exp_full, found, rel_ok, rel_pending;
        int          exp_seat, exp_probes, c, wr_cycle, wr_count, av_cycle, b;
        logic [31:0] prev_sno, wr_sno;
        logic [4:0]  prev_seat, wr_seat, av_seat;
        logic        av_full;
        exp_full   = (model_free() == 0);
        found      = 1'b0;
        exp_seat   = 0;
        exp_probes = 0;
        for (int d = 0; d < N; d++) begin
            if (!found && !model_occ[(model_ptr + d) % N]) begin
                found      = 1'b1;
                exp_seat   = (model_ptr + d) % N;
                exp_probes = d + 1;
            end
        end
        rel_ok = rel_en && !exp_full && (int'(rel_seat) < N) && model_occ[rel_seat]
                 && (int'(rel_seat) != exp_seat);

        b = 0;
        while (req_ready !== 1'b1 && b < 20) begin
            tick();
            b++;
        end
        check("req_ready_before", 64'(req_ready), 64'(1));
        req_valid      = 1'b1;
        req_student_no = sno;
        tick();
        req_valid      = 1'b0;
        req_student_no = $urandom();

        c = 1; wr_cycle = 0; wr_count = 0; av_cycle = 0; rel_pending = 1'b0;
        prev_sno = '0; prev_seat = '0; wr_sno = '0; wr_seat = '0; av_seat = '0; av_full = 1'b0;
        while (av_cycle == 0 && c <= 2 * N + 8) begin
            if (write_mem1 === 1'b1) begin
                if (wr_count == 0) begin
                    wr_cycle = c;
                    wr_sno   = Student_No_mem1;
                    wr_seat  = Seat_No_mem1;
                    if (rel_en) begin
                        rel_valid   = 1'b1;
                        rel_seat_no = rel_seat;
                        rel_pending = 1'b1;
                    end
                end
                wr_count++;
            end else if (wr_count == 0) begin
                prev_sno  = Student_No_mem1;
                prev_seat = Seat_No_mem1;
            end
            if (assign_valid === 1'b1) begin
                av_cycle = c;
                av_full  = assign_full;
                av_seat  = assign_seat_no;
            end
            tick();
            rel_valid = 1'b0;
            if (rel_pending) begin
                check("wr_rel_err", 64'(rel_err), 64'(!rel_ok));
                rel_pending = 1'b0;
            end
            c++;
        end

        check("assign_seen", 64'(av_cycle != 0), 64'(1));
        check("assign_full", 64'(av_full), 64'(exp_full));
        if (exp_full) begin
            check("full_latency",  64'(av_cycle), 64'(1));
            check("full_no_write", 64'(wr_count), 64'(0));
        end else begin
            check("write_count",   64'(wr_count),  64'(1));
            check("write_latency", 64'(wr_cycle),  64'(exp_probes + 1));
            check("assign_latency",64'(av_cycle),  64'(exp_probes + 2));
            check("wr_student",    64'(wr_sno),    64'(sno));
            check("wr_seat",       64'(wr_seat),   64'(exp_seat));
            check("pre_student",   64'(prev_sno),  64'(sno));
            check("pre_seat",      64'(prev_seat), 64'(exp_seat));
            check("assign_seat",   64'(av_seat),   64'(exp_seat));
            model_occ[exp_seat] = 1'b1;
            model_ptr = (exp_seat + 1) % N;
            if (rel_ok) model_occ[rel_seat] = 1'b0;
        end
        check("ready_after", 64'(req_ready), 64'(1));
        check("free_after",  64'(free_count), 64'(model_free()));
        g_av_seat  = int'(av_seat);
        g_wr_cycle = wr_cycle;
    endtask

    initial begin
        int wcount;
        int c;
        model_reset();

        // Reset state on both instances.
        repeat (3) tick();
        check_reset_outputs("reset");
        check("t20_reset_free", 64'(t20_free_count), 64'(20));
        reset_n = 1'b1;
        tick();
        check("ready_after_reset", 64'(req_ready), 64'(1));

        // Releasing a free seat is refused and leaves the count alone.
        do_release(5'd7);
        check("bad_rel_free", 64'(free_count), 64'(N));

        // Out-of-range and free-seat releases on the 20-seat instance.
        t20_rel_valid = 1'b1; t20_rel_seat_no = 5'd25;
        tick();
        t20_rel_valid = 1'b0;
        check("t20_rel25_err", 64'(t20_rel_err), 64'(1));
        check("t20_rel25_free", 64'(t20_free_count), 64'(20));
        t20_rel_valid = 1'b1; t20_rel_seat_no = 5'd19;
        tick();
        t20_rel_valid = 1'b0;
        check("t20_rel19_err", 64'(t20_rel_err), 64'(1));
        t20_req_valid = 1'b1; t20_req_student_no = 32'd55;
        tick();
        t20_req_valid = 1'b0;
        c = 0;
        while (t20_assign_valid !== 1'b1 && c < 20) begin
            tick();
            c++;
        end
        check("t20_assign_seat", 64'(t20_assign_seat_no), 64'(0));
        check("t20_assign_full", 64'(t20_assign_full), 64'(0));
        tick();
        check("t20_free_after", 64'(t20_free_count), 64'(19));
        t20_rel_valid = 1'b1; t20_rel_seat_no = 5'd0;
        tick();
        t20_rel_valid = 1'b0;
        check("t20_rel0_ok", 64'(t20_rel_err), 64'(0));
        check("t20_free_back", 64'(t20_free_count), 64'(20));

        // Fill all seats in order.
        for (int i = 0; i < N; i++) begin
            do_request(32'(1000 + i), 1'b0, 5'd0);
            check("fill_seat", 64'(g_av_seat), 64'(i));
            check("fill_free", 64'(free_count), 64'(N - 1 - i));
        end

        // Table full: rejected without a write.
        do_request(32'd2000, 1'b0, 5'd0);
        check("full_wr_cycle", 64'(g_wr_cycle), 64'(0));

        // Round-robin pick-up of released seats.
        do_release(5'd3);
        do_release(5'd17);
        do_request(32'd3000, 1'b0, 5'd0);
        check("rr_3000_seat", 64'(g_av_seat), 64'(3));
        check("rr_3000_wrcyc", 64'(g_wr_cycle), 64'(5));
        do_request(32'd3001, 1'b0, 5'd0);
        check("rr_3001_seat", 64'(g_av_seat), 64'(17));

        // Release of another seat during the write of seat 9.
        do_release(5'd9);
        do_request(32'd4000, 1'b1, 5'd5);
        check("sim_seat9", 64'(g_av_seat), 64'(9));
        check("sim_free_unchanged", 64'(free_count), 64'(1));
        do_request(32'd4001, 1'b0, 5'd0);
        check("sim_refill5", 64'(g_av_seat), 64'(5));
        // Release of the very seat being written is refused.
        do_release(5'd9);
        do_request(32'd4002, 1'b1, 5'd9);
        check("sim_self_seat", 64'(g_av_seat), 64'(9));
        check("sim_self_free", 64'(free_count), 64'(0));
        do_release(5'd9);

        // Randomized traffic.
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 2) != 0) do_request($urandom(), 1'b0, 5'd0);
            else do_release(5'($urandom_range(0, 31)));
        end

        // Reset in the middle of a long search.
        while (model_free() > 0) do_request($urandom(), 1'b0, 5'd0);
        do_release(5'((model_ptr + N - 1) % N));
        req_valid = 1'b1; req_student_no = 32'hCAFE;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check("rst_mid_searching", 64'(write_mem1), 64'(0));
        reset_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        model_reset();
        #2;
        reset_n = 1'b1;
        tick();
        check("rst_mid_ready", 64'(req_ready), 64'(1));
        wcount = 0;
        for (int i = 0; i < 40; i++) begin
            if (write_mem1 === 1'b1) wcount++;
            tick();
        end
        check("rst_mid_no_write", 64'(wcount), 64'(0));
        check("rst_mid_free", 64'(free_count), 64'(N));

        // Reset cuts a write strobe that is already high.
        req_valid = 1'b1; req_student_no = 32'hBEEF;
        tick();
        req_valid = 1'b0;
        tick();
        check("cut_write_high", 64'(write_mem1), 64'(1));
        reset_n = 1'b0;
        #1;
        check("cut_write_low", 64'(write_mem1), 64'(0));
        model_reset();
        #2;
        reset_n = 1'b1;
        tick();
        do_request(32'd7777, 1'b0, 5'd0);
        check("post_cut_seat", 64'(g_av_seat), 64'(0));

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL timeout: simulation did not finish, %0d vectors applied", n_vec);
        $fatal(1, "timeout");
    end

endmodule
